cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser.sv | 178 +++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// Command frame parser: pulls 8-byte frames (HDR0 HDR1 CMD ARG P0 P1 P2 CHK)
// out of a command RX FIFO, validates header, checksum and command code, and
// drives the CPU switch outputs. Define CMD_REPLY_EN to enable the 4-byte
// status reply to the CPU UART TX FIFOs; without it the reply path is absent.
module cmd_frame_parser #(
  parameter int         UART_FIFO_COUNTER_W = 8,
  parameter logic [7:0] HDR0                = 8'hEB,
  parameter logic [7:0] HDR1                = 8'h90
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [UART_FIFO_COUNTER_W-1:0] com_count,
  input  logic [7:0]                     rec_command,
  output logic                           com_pop,
  input  logic                           switch,
  output logic                           force_swi,
  output logic                           com_swi,
  output logic                           error,
  output logic [7:0]                     bad_cnt,
  output logic [7:0]                     tdr_cpuAB,
  output logic                           tf_push_cpuAB
);

  localparam logic [UART_FIFO_COUNTER_W-1:0] FRAME_LEN = UART_FIFO_COUNTER_W'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_CHECK,
    S_EXEC
`ifdef CMD_REPLY_EN
    , S_REPLY
`endif
  } state_t;

  state_t     r_state;
  logic [2:0] r_k;
  logic [7:0] r_frame [0:7];
  logic       r_frame_ok;
  logic       r_com_pop;
  logic       r_force_swi;
  logic       r_com_swi;
  logic       r_error;
  logic [7:0] r_bad_cnt;

  logic [7:0] w_sum;
  logic       w_cmd_ok;
  logic       w_hdr_bad;

  // Checksum covers CMD..P2; only commands 01..03 are recognised.
  assign w_sum     = r_frame[2] + r_frame[3] + r_frame[4] + r_frame[5] + r_frame[6];
  assign w_cmd_ok  = (r_frame[2] == 8'h01) || (r_frame[2] == 8'h02) || (r_frame[2] == 8'h03);
  // Header resync: a wrong byte 0 or byte 1 drops the partial frame.
  assign w_hdr_bad = ((r_k == 3'd0) && (rec_command != HDR0)) ||
                     ((r_k == 3'd1) && (rec_command != HDR1));

`ifdef CMD_REPLY_EN
  logic [2:0] r_rep_cnt;
  logic [7:0] r_tdr;
  logic       r_push;
`endif

  // Frame FSM with all strobes and levels registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_frame_ok  <= 1'b0;
      r_com_pop   <= 1'b0;
      r_force_swi <= 1'b0;
      r_com_swi   <= 1'b0;
      r_error     <= 1'b0;
      r_bad_cnt   <= 8'h00;
      for (int i = 0; i < 8; i++) r_frame[i] <= 8'h00;
`ifdef CMD_REPLY_EN
      r_rep_cnt   <= 3'd0;
      r_tdr       <= 8'h00;
      r_push      <= 1'b0;
`endif
    end else begin
      r_com_pop   <= 1'b0;
      r_force_swi <= 1'b0;
`ifdef CMD_REPLY_EN
      r_push      <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_k <= 3'd0;
          if (com_count >= FRAME_LEN) begin
            r_com_pop <= 1'b1;
            r_state   <= S_POP;
          end
        end
        S_POP: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_frame[r_k] <= rec_command;
          if (w_hdr_bad) begin
            r_k     <= 3'd0;
            r_state <= S_IDLE;
          end else if (r_k == 3'd7) begin
            r_k     <= 3'd0;
            r_state <= S_CHECK;
          end else begin
            r_k       <= r_k + 3'd1;
            r_com_pop <= 1'b1;
            r_state   <= S_POP;
          end
        end
        S_CHECK: begin
          r_frame_ok <= (r_frame[0] == HDR0) && (r_frame[1] == HDR1) &&
                        (w_sum == r_frame[7]) && w_cmd_ok;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          if (!r_frame_ok) begin
            r_error <= 1'b1;
            if (r_bad_cnt != 8'hFF) r_bad_cnt <= r_bad_cnt + 8'd1;
          end else begin
            r_error <= 1'b0;
            if (r_frame[2] == 8'h01) begin
              r_com_swi   <= 1'b0;
              r_force_swi <= 1'b1;
            end else if (r_frame[2] == 8'h02) begin
              r_com_swi   <= 1'b1;
              r_force_swi <= 1'b1;
            end
`ifdef CMD_REPLY_EN
            r_rep_cnt <= 3'd0;
            r_state   <= S_REPLY;
`endif
          end
        end
`ifdef CMD_REPLY_EN
        S_REPLY: begin
          // Even counts push a byte, odd counts are gaps between pushes.
          if (!r_rep_cnt[0]) begin
            r_push <= 1'b1;
            case (r_rep_cnt[2:1])
              2'd0:    r_tdr <= HDR0;
              2'd1:    r_tdr <= HDR1;
              2'd2:    r_tdr <= r_frame[2];
              default: r_tdr <= {5'b0, r_error, r_com_swi, switch};
            endcase
          end
          if (r_rep_cnt == 3'd6) begin
            r_rep_cnt <= 3'd0;
            r_state   <= S_IDLE;
          end else begin
            r_rep_cnt <= r_rep_cnt + 3'd1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign com_pop   = r_com_pop;
  assign force_swi = r_force_swi;
  assign com_swi   = r_com_swi;
  assign error     = r_error;
  assign bad_cnt   = r_bad_cnt;

`ifdef CMD_REPLY_EN
  assign tdr_cpuAB     = r_tdr;
  assign tf_push_cpuAB = r_push;
`else
  logic w_unused_switch;
  assign w_unused_switch = switch;
  assign tdr_cpuAB       = 8'h00;
  assign tf_push_cpuAB   = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frames, random byte streams and reset
// scenarios compared with a stream-level reference parser.
module tb_cmd_frame_parser;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] com_count = '0;
  logic [7:0]    rec_command = 8'h00;
  logic          com_pop;
  logic          switch = 1'b0;
  logic          force_swi;
  logic          com_swi;
  logic          error;
  logic [7:0]    bad_cnt;
  logic [7:0]    tdr_cpuAB;
  logic          tf_push_cpuAB;

  cmd_frame_parser #(.UART_FIFO_COUNTER_W(CW), .HDR0(8'hEB), .HDR1(8'h90)) dut (
    .clk(clk), .rst_n(rst_n), .com_count(com_count), .rec_command(rec_command),
    .com_pop(com_pop), .switch(switch), .force_swi(force_swi), .com_swi(com_swi),
    .error(error), .bad_cnt(bad_cnt), .tdr_cpuAB(tdr_cpuAB), .tf_push_cpuAB(tf_push_cpuAB)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO contents and observed events
  logic [7:0] fifo_q[$];
  int cyc = 0;
  int last_act = 0;
  int pop_cnt = 0;
  int pop_empty = 0;
  int pop_cyc[$];
  int force_cyc[$];
  int push_cyc[$];
  logic ev_force[$];
  logic [7:0] ev_push[$];

  // Reference model state
  logic [7:0] m_stream[$];
  logic m_sw = 1'b0;
  logic m_err = 1'b0;
  int m_bad = 0;
  int exp_pops = 0;
  logic exp_force[$];
  logic [7:0] exp_push[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic upd_count();
    com_count = (fifo_q.size() > 255) ? CW'(255) : CW'(fifo_q.size());
  endtask

  // FIFO model and event monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (com_pop) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
        last_act = cyc;
        if (fifo_q.size() == 0) pop_empty++;
        else rec_command = fifo_q.pop_front();
      end
      if (force_swi) begin
        ev_force.push_back(com_swi);
        force_cyc.push_back(cyc);
        last_act = cyc;
      end
      if (tf_push_cpuAB) begin
        ev_push.push_back(tdr_cpuAB);
        push_cyc.push_back(cyc);
        last_act = cyc;
      end
    end
    upd_count();
  end

  task automatic add_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    m_stream.push_back(b);
    upd_count();
  endtask

  task automatic add_frame(input logic [7:0] cmd, input logic [7:0] arg,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] chk);
    add_byte(8'hEB); add_byte(8'h90); add_byte(cmd); add_byte(arg);
    add_byte(p0); add_byte(p1); add_byte(p2); add_byte(chk);
  endtask

  // Parse the pending stream the way the frame rules describe it.
  task automatic model_run();
    logic [7:0] f[8];
    logic [7:0] s;
    while (m_stream.size() >= 8) begin
      if (m_stream[0] != 8'hEB) begin
        void'(m_stream.pop_front()); exp_pops += 1;
      end else if (m_stream[1] != 8'h90) begin
        void'(m_stream.pop_front()); void'(m_stream.pop_front()); exp_pops += 2;
      end else begin
        for (int i = 0; i < 8; i++) f[i] = m_stream.pop_front();
        exp_pops += 8;
        s = f[2] + f[3] + f[4] + f[5] + f[6];
        if (s != f[7] || f[2] < 8'h01 || f[2] > 8'h03) begin
          m_err = 1'b1;
          if (m_bad < 255) m_bad++;
        end else begin
          m_err = 1'b0;
          if (f[2] == 8'h01) begin m_sw = 1'b0; exp_force.push_back(1'b0); end
          if (f[2] == 8'h02) begin m_sw = 1'b1; exp_force.push_back(1'b1); end
`ifdef CMD_REPLY_EN
          exp_push.push_back(8'hEB);
          exp_push.push_back(8'h90);
          exp_push.push_back(f[2]);
          exp_push.push_back({5'b0, m_err, m_sw, switch});
`endif
        end
      end
    end
  endtask

  task automatic clear_events();
    pop_cnt = 0; pop_empty = 0; exp_pops = 0;
    pop_cyc.delete(); force_cyc.delete(); push_cyc.delete();
    ev_force.delete(); ev_push.delete(); exp_force.delete(); exp_push.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && !(fifo_q.size() < 8 && (cyc - last_act) > 30)) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_val("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic check_batch(input string name);
    check_val({name, "_pops"}, pop_cnt, exp_pops);
    check_val({name, "_pop_empty"}, pop_empty, 0);
    check_val({name, "_nforce"}, ev_force.size(), exp_force.size());
    for (int i = 0; i < ev_force.size() && i < exp_force.size(); i++)
      check_val({name, "_force_swi_val"}, ev_force[i], exp_force[i]);
    check_val({name, "_npush"}, ev_push.size(), exp_push.size());
    for (int i = 0; i < ev_push.size() && i < exp_push.size(); i++)
      check_val({name, "_push_byte"}, ev_push[i], exp_push[i]);
    check_val({name, "_error"}, error, m_err);
    check_val({name, "_bad_cnt"}, bad_cnt, m_bad);
    check_val({name, "_com_swi"}, com_swi, m_sw);
    $display("batch %s: pops=%0d forces=%0d pushes=%0d error=%0b bad_cnt=%0d com_swi=%0b",
             name, pop_cnt, ev_force.size(), ev_push.size(), error, bad_cnt, com_swi);
    clear_events();
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "_com_pop"}, com_pop, 0);
    check_val({name, "_force_swi"}, force_swi, 0);
    check_val({name, "_com_swi"}, com_swi, 0);
    check_val({name, "_error"}, error, 0);
    check_val({name, "_bad_cnt"}, bad_cnt, 0);
    check_val({name, "_tdr"}, tdr_cpuAB, 0);
    check_val({name, "_push"}, tf_push_cpuAB, 0);
  endtask

  initial begin
    logic [7:0] c, a, p0, p1, p2, sum;
    int kind, n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Switch-to-B frame with pop spacing and strobe latency
    #2;
    add_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    model_run();
    drain(400);
    check_val("d1_npops_timing", pop_cyc.size(), 8);
    if (pop_cyc.size() >= 8)
      for (int i = 0; i < 7; i++) check_val("d1_pop_gap", pop_cyc[i+1] - pop_cyc[i], 2);
    if (pop_cyc.size() >= 1 && force_cyc.size() >= 1)
      check_val("d1_force_lat", force_cyc[0] - pop_cyc[0], 18);
    check_batch("d1_switch_b");

    // Bad checksum frame
    #2;
    add_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05);
    model_run();
    drain(400);
    check_batch("d2_bad_chk");

    // Leading junk byte then switch-to-A frame
    #2;
    add_byte(8'h55);
    add_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    model_run();
    drain(400);
    check_batch("d3_resync");

    // Status frame with switch=1
    switch = 1'b1;
    #2;
    add_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    model_run();
    drain(400);
    if (push_cyc.size() == 4)
      for (int i = 0; i < 3; i++) check_val("d4_push_gap", push_cyc[i+1] - push_cyc[i], 2);
    check_batch("d4_status");

    // Random streams
    for (int b = 0; b < 40; b++) begin
      switch = 1'($urandom_range(0, 1));
      #2;
      n = $urandom_range(1, 4);
      for (int f = 0; f < n; f++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) add_byte(8'($urandom_range(0, 255)));
        c  = (kind == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 3));
        a  = 8'($urandom); p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
        sum = c + a + p0 + p1 + p2;
        if (kind == 2) sum = sum + 8'($urandom_range(1, 255));
        if (kind == 3) begin
          add_byte(8'hEB); add_byte(8'($urandom_range(0, 255)));
        end else begin
          add_frame(c, a, p0, p1, p2, sum);
        end
      end
      model_run();
      drain(1500);
      check_batch("rand");
    end

    // Reset in mid-frame
    switch = 1'b0;
    #2;
    add_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02);
    n = 0;
    while (pop_cnt < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_val("rst_wait_pops", 32'(pop_cnt >= 3), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    fifo_q.delete(); m_stream.delete(); upd_count();
    m_sw = 1'b0; m_err = 1'b0; m_bad = 0;
    clear_events();
    add_byte(8'hEB); add_byte(8'h90); add_byte(8'h03); add_byte(8'h00); add_byte(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("rst_no_pop_below8", pop_cnt, 0);
    check_val("rst_no_force", ev_force.size(), 0);
    check_val("rst_no_push", ev_push.size(), 0);
    add_byte(8'h00); add_byte(8'h00); add_byte(8'h03);
    model_run();
    drain(400);
    check_batch("rst_resume");

    // 300 bad frames saturate bad_cnt, then one valid frame
    for (int ch = 0; ch < 12; ch++) begin
      #2;
      for (int f = 0; f < 25; f++) begin
        c = 8'($urandom_range(1, 3)); a = 8'($urandom); p0 = 8'($urandom);
        sum = c + a + p0 + 8'($urandom_range(1, 255));
        add_frame(c, a, p0, 8'h00, 8'h00, sum);
      end
      model_run();
      drain(2000);
      check_batch("sat");
    end
    check_val("sat_bad_cnt_255", bad_cnt, 255);
    check_val("sat_error", error, 1);
    #2;
    add_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    model_run();
    drain(400);
    check_val("sat_valid_error", error, 0);
    check_val("sat_valid_bad_cnt", bad_cnt, 255);
    check_batch("sat_valid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit reached");
  end

endmodule
